layer_scheduler: RTL and testbench
==================================

Name: layer_scheduler

Overview:
Top-level layer sequencer for the CNN-FC accelerator. It walks the network layer by layer:
- requests the next layer descriptor from the network-structure block;
- launches either the conv FSM or the FC FSM on the shared MAC array and memory;
- waits for that FSM to finish;
- swaps the ping-pong ifmap/ofmap base addresses.

It sits above fsm_fc and the conv FSM, and drives their start and if_base inputs.

Parameters:
ADDRESS_BITS, 6, width of memory base addresses
LAYER_BITS, 4, width of layer counter / layer count
PING_BASE, 0, ifmap base for layer 0
PONG_BASE, 32, ofmap base for layer 0

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
start  in  1  run request, sampled in IDLE only
cant_layers  in  LAYER_BITS  number of layers; sampled on accepted start
struct_ready  in  1  descriptor valid (level) from network-structure block
layer_is_fc  in  1  descriptor type: 1 = FC, 0 = conv; sampled with struct_ready
conv_done  in  1  conv FSM completion pulse
fc_done  in  1  FC FSM completion pulse
next_layer  out  1  one-cycle request to advance the descriptor
start_conv  out  1  one-cycle launch of the conv FSM
start_fc  out  1  one-cycle launch of fsm_fc
if_base  out  ADDRESS_BITS  ifmap base for the current layer
of_base  out  ADDRESS_BITS  ofmap base for the current layer
layer_idx  out  LAYER_BITS  index of the current layer
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse when all layers have completed

Behaviour:
- All outputs are registered.
- Reset values: next_layer, start_conv, start_fc, busy and done = 0; if_base = PING_BASE; of_base = PONG_BASE; layer_idx = 0; state = IDLE.
- States: IDLE, FETCH, LAUNCH, RUN, SWAP, FINISH.
- IDLE:
  - start=1 and cant_layers>0: latch cant_layers, go to FETCH. Next cycle: busy=1, next_layer=1 for exactly one cycle, layer_idx=0, bases at reset values.
  - start=1 and cant_layers=0: go to FINISH (done pulse; no next_layer, no launch).
- FETCH: hold until struct_ready is sampled 1. On that edge, latch layer_is_fc and go to LAUNCH. Wait is unbounded unless the watchdog is enabled.
- LAUNCH: exactly one of start_fc / start_conv is 1 for one cycle, per the latched type. Then go to RUN.
- RUN:
  - Wait for the done pulse of the selected engine only; the other engine's done is ignored.
  - A done arriving in the same cycle as the launch is not accepted; done is counted only from RUN.
- SWAP (one cycle):
  - Exchange if_base and of_base; increment layer_idx.
  - If the new layer_idx equals the latched cant_layers: go to FINISH, with layer_idx held at cant_layers.
  - Otherwise go to FETCH, which pulses next_layer again.
- FINISH: done=1 for one cycle, busy=0 from that cycle, return to IDLE. Bases are not restored; the final of_base holds the network output.
- Restart: the next start accepted in IDLE resets the bases to PING/PONG and layer_idx to 0.
- start while not IDLE: ignored.
- Layer latency per layer: 1 (FETCH minimum) + 1 (LAUNCH) + engine time + 1 (SWAP) cycles.
- rst asserted in any state: next edge returns all state and outputs to reset values; any in-flight pulse is dropped.
- cant_layers wider than its width cannot occur. A layer counter reaching 2^LAYER_BITS−1 is legal.

Optional Feature:
- Macro: SCHED_WATCHDOG_EN.
- When defined:
  - Adds parameter WDOG_CYCLES (default 4095) and output port wdog_err (1 bit, reset 0).
  - A counter runs in FETCH and RUN and is cleared on every state change.
  - On reaching WDOG_CYCLES: wdog_err=1 (sticky until rst or the next accepted start), state goes to FINISH, done pulses.
- When undefined: no counter, no port; waits are unbounded.

Decomposition:
- Shared package cnn_fc_pkg:
  - state enum sched_state_t (IDLE, FETCH, LAUNCH, RUN, SWAP, FINISH);
  - localparam for the layer type encoding (LAYER_CONV = 0, LAYER_FC = 1).
- One natural sub-module: pingpong_base. It holds if_base/of_base, with swap and reload controls.

Test Plan:
- Reset and idle: rst high for 2 cycles → all outputs at reset values, if_base=0, of_base=32; start=0 for 20 cycles → no output changes.
- Three-layer run: cant_layers=3, types conv, conv, FC, each engine done 10 cycles after its launch → next_layer pulses 3 times; start_conv, start_conv, start_fc; bases (0,32), (32,0), (0,32); layer_idx 0, 1, 2; one done pulse; busy low after.
- Zero layers: cant_layers=0, start=1 → done pulse 2 cycles after start; no next_layer, start_conv or start_fc.
- Wrong-engine done: FC layer in RUN, conv_done pulsed → stays in RUN; fc_done → SWAP.
- Mid-run reset and ignored start: start pulsed during RUN → no effect; rst during RUN → next cycle busy=0, bases 0/32; a fresh start runs normally.
- Watchdog (SCHED_WATCHDOG_EN, WDOG_CYCLES=50): struct_ready held 0 → wdog_err=1 and done pulse 50 cycles after FETCH entry.

Source files
------------

// File: rtl/cnn_fc_pkg.sv
// -----------------------------------------------------------------------------
// cnn_fc_pkg
// Shared definitions for the CNN-FC accelerator control path.
//   sched_state_t : layer scheduler states
//   LAYER_CONV / LAYER_FC : encoding of the descriptor's layer type bit
// -----------------------------------------------------------------------------
package cnn_fc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LAUNCH = 3'd2,
    RUN    = 3'd3,
    SWAP   = 3'd4,
    FINISH = 3'd5
  } sched_state_t;

  localparam logic LAYER_CONV = 1'b0;
  localparam logic LAYER_FC   = 1'b1;

endpackage

// File: rtl/layer_scheduler_pingpong_base.sv
// -----------------------------------------------------------------------------
// pingpong_base
// Holds the ifmap/ofmap base address pair used by the layer engines.
//   clk, rst  : clock, synchronous active-high reset
//   reload_i  : restore the PING/PONG pair (new network run)
//   swap_i    : exchange the two bases (end of a layer)
//   if_base_o : current ifmap base (registered)
//   of_base_o : current ofmap base (registered)
// reload_i takes priority over swap_i.
// -----------------------------------------------------------------------------
module pingpong_base #(
  parameter int ADDRESS_BITS = 6,
  parameter int PING_BASE    = 0,
  parameter int PONG_BASE    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    reload_i,
  input  logic                    swap_i,
  output logic [ADDRESS_BITS-1:0] if_base_o,
  output logic [ADDRESS_BITS-1:0] of_base_o
);

  localparam logic [ADDRESS_BITS-1:0] PING = ADDRESS_BITS'(PING_BASE);
  localparam logic [ADDRESS_BITS-1:0] PONG = ADDRESS_BITS'(PONG_BASE);

  logic [ADDRESS_BITS-1:0] if_base_q, if_base_d;
  logic [ADDRESS_BITS-1:0] of_base_q, of_base_d;

  // Next-state selection for the base pair
  always_comb begin
    if_base_d = if_base_q;
    of_base_d = of_base_q;
    if (reload_i) begin
      if_base_d = PING;
      of_base_d = PONG;
    end else if (swap_i) begin
      if_base_d = of_base_q;
      of_base_d = if_base_q;
    end else begin
      if_base_d = if_base_q;
      of_base_d = of_base_q;
    end
  end

  // Base pair registers
  always_ff @(posedge clk) begin
    if (rst) begin
      if_base_q <= PING;
      of_base_q <= PONG;
    end else begin
      if_base_q <= if_base_d;
      of_base_q <= of_base_d;
    end
  end

  assign if_base_o = if_base_q;
  assign of_base_o = of_base_q;

endmodule

// File: rtl/layer_scheduler.sv
// -----------------------------------------------------------------------------
// layer_scheduler
// Walks the network one layer at a time: fetches a descriptor, launches the
// conv or FC engine, waits for that engine's completion, swaps ping-pong bases.
//   clk, rst          : clock, synchronous active-high reset
//   start             : run request (IDLE only); cant_layers latched with it
//   struct_ready      : descriptor valid level; layer_is_fc sampled with it
//   conv_done/fc_done : engine completion pulses
//   next_layer        : one-cycle descriptor advance request
//   start_conv/start_fc : one-cycle engine launch
//   if_base/of_base   : base addresses for the current layer
//   layer_idx         : current layer index
//   busy / done       : run in progress / one-cycle completion pulse
// Optional: define SCHED_WATCHDOG_EN to add parameter WDOG_CYCLES and output
// wdog_err. A stall of WDOG_CYCLES cycles in FETCH or RUN aborts the run.
// -----------------------------------------------------------------------------
module layer_scheduler
  import cnn_fc_pkg::*;
#(
  parameter int ADDRESS_BITS = 6,
  parameter int LAYER_BITS   = 4,
  parameter int PING_BASE    = 0,
  parameter int PONG_BASE    = 32
`ifdef SCHED_WATCHDOG_EN
  ,parameter int WDOG_CYCLES = 4095
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LAYER_BITS-1:0]   cant_layers,
  input  logic                    struct_ready,
  input  logic                    layer_is_fc,
  input  logic                    conv_done,
  input  logic                    fc_done,
  output logic                    next_layer,
  output logic                    start_conv,
  output logic                    start_fc,
  output logic [ADDRESS_BITS-1:0] if_base,
  output logic [ADDRESS_BITS-1:0] of_base,
  output logic [LAYER_BITS-1:0]   layer_idx,
  output logic                    busy,
  output logic                    done
`ifdef SCHED_WATCHDOG_EN
  ,output logic                   wdog_err
`endif
);

  sched_state_t          state_q;
  logic [LAYER_BITS-1:0] cant_q;
  logic [LAYER_BITS-1:0] layer_idx_q;
  logic                  type_q;
  logic                  next_layer_q;
  logic                  start_conv_q;
  logic                  start_fc_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  base_reload;
  logic                  base_swap;
  logic                  engine_done;
  logic [LAYER_BITS-1:0] layer_idx_inc;

  // Bases reload on the accepting edge so they are valid alongside next_layer
  assign base_reload   = (state_q == IDLE) && start;
  assign base_swap     = (state_q == SWAP);
  // Only the engine that was launched can end the layer
  assign engine_done   = (type_q == LAYER_FC) ? fc_done : conv_done;
  assign layer_idx_inc = layer_idx_q + LAYER_BITS'(1);

`ifdef SCHED_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_cnt_q;
  logic              wdog_err_q;
  logic              wdog_hit;
  // Counter holds (cycles already spent in state - 1); this edge is the last allowed one
  assign wdog_hit = (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1));
`endif

  pingpong_base #(
    .ADDRESS_BITS (ADDRESS_BITS),
    .PING_BASE    (PING_BASE),
    .PONG_BASE    (PONG_BASE)
  ) u_bases (
    .clk       (clk),
    .rst       (rst),
    .reload_i  (base_reload),
    .swap_i    (base_swap),
    .if_base_o (if_base),
    .of_base_o (of_base)
  );

  // Layer sequencing FSM with registered pulse/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cant_q       <= '0;
      layer_idx_q  <= '0;
      type_q       <= LAYER_CONV;
      next_layer_q <= 1'b0;
      start_conv_q <= 1'b0;
      start_fc_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef SCHED_WATCHDOG_EN
      wdog_cnt_q   <= '0;
      wdog_err_q   <= 1'b0;
`endif
    end else begin
      // Pulses default low; the counter clears on any state change
      next_layer_q <= 1'b0;
      start_conv_q <= 1'b0;
      start_fc_q   <= 1'b0;
      done_q       <= 1'b0;
`ifdef SCHED_WATCHDOG_EN
      wdog_cnt_q   <= '0;
`endif
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q      <= 1'b1;
            layer_idx_q <= '0;
`ifdef SCHED_WATCHDOG_EN
            wdog_err_q  <= 1'b0;
`endif
            if (cant_layers != {LAYER_BITS{1'b0}}) begin
              cant_q       <= cant_layers;
              next_layer_q <= 1'b1;
              state_q      <= FETCH;
            end else begin
              state_q <= FINISH;
            end
          end
        end
        FETCH: begin
          if (struct_ready) begin
            // Launch pulse is raised on entry so it is visible during LAUNCH
            type_q       <= layer_is_fc;
            start_fc_q   <= layer_is_fc;
            start_conv_q <= ~layer_is_fc;
            state_q      <= LAUNCH;
          end
`ifdef SCHED_WATCHDOG_EN
          else if (wdog_hit) begin
            wdog_err_q <= 1'b1;
            state_q    <= FINISH;
          end else begin
            wdog_cnt_q <= wdog_cnt_q + WDOG_W'(1);
          end
`endif
        end
        LAUNCH: begin
          // A done arriving alongside the launch pulse is deliberately not looked at
          state_q <= RUN;
        end
        RUN: begin
          if (engine_done) begin
            state_q <= SWAP;
          end
`ifdef SCHED_WATCHDOG_EN
          else if (wdog_hit) begin
            wdog_err_q <= 1'b1;
            state_q    <= FINISH;
          end else begin
            wdog_cnt_q <= wdog_cnt_q + WDOG_W'(1);
          end
`endif
        end
        SWAP: begin
          layer_idx_q <= layer_idx_inc;
          if (layer_idx_inc == cant_q) begin
            state_q <= FINISH;
          end else begin
            next_layer_q <= 1'b1;
            state_q      <= FETCH;
          end
        end
        FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign next_layer = next_layer_q;
  assign start_conv = start_conv_q;
  assign start_fc   = start_fc_q;
  assign layer_idx  = layer_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef SCHED_WATCHDOG_EN
  assign wdog_err   = wdog_err_q;
`endif

endmodule

// File: tb/tb_layer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_layer_scheduler
// Randomized bench for layer_scheduler. A cycle-level reference model built
// from the sequencing rules (event tick arithmetic) predicts every pulse,
// busy, and the bases/index at each launch and at completion. The bench also
// plays the structure block and both engines, including stray done pulses.
// -----------------------------------------------------------------------------
module tb_layer_scheduler;

  localparam int AB   = 6;
  localparam int LB   = 4;
  localparam int PING = 0;
  localparam int PONG = 32;

  logic          clk = 1'b0;
  logic          rst, start, struct_ready, layer_is_fc, conv_done, fc_done;
  logic [LB-1:0] cant_layers;
  logic          next_layer, start_conv, start_fc, busy, done;
  logic [AB-1:0] if_base, of_base;
  logic [LB-1:0] layer_idx;
`ifdef SCHED_WATCHDOG_EN
  logic          wdog_err;
`endif

  always #5 clk = ~clk;

  layer_scheduler #(
    .ADDRESS_BITS (AB),
    .LAYER_BITS   (LB),
    .PING_BASE    (PING),
    .PONG_BASE    (PONG)
`ifdef SCHED_WATCHDOG_EN
    ,.WDOG_CYCLES (50)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cant_layers  (cant_layers),
    .struct_ready (struct_ready),
    .layer_is_fc  (layer_is_fc),
    .conv_done    (conv_done),
    .fc_done      (fc_done),
    .next_layer   (next_layer),
    .start_conv   (start_conv),
    .start_fc     (start_fc),
    .if_base      (if_base),
    .of_base      (of_base),
    .layer_idx    (layer_idx),
    .busy         (busy),
    .done         (done)
`ifdef SCHED_WATCHDOG_EN
    ,.wdog_err    (wdog_err)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state: expected event ticks and environment progress
  int exp_nl_tick, exp_launch_tick, exp_done_tick, busy_on_tick;
  bit busy_exp;
  bit types[16];
  int n_layers, cur_layer;
  int rdy_wait, eng_wait;
  bit eng_fc;
  bit hold_rdy = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (tick %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: sample after the edge, compare with the model, then drive the environment
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    conv_done = 1'b0;
    fc_done   = 1'b0;
    start     = 1'b0;
    if (cyc == busy_on_tick)  busy_exp = 1'b1;
    if (cyc == exp_done_tick) busy_exp = 1'b0;
    check("next_layer", next_layer, cyc == exp_nl_tick);
    check("start_conv", start_conv, (cyc == exp_launch_tick) && !types[cur_layer]);
    check("start_fc",   start_fc,   (cyc == exp_launch_tick) &&  types[cur_layer]);
    check("done",       done,       cyc == exp_done_tick);
    check("busy",       busy,       busy_exp);
    if (cyc == exp_nl_tick) begin
      check("nl_layer_idx", layer_idx, cur_layer);
      rdy_wait = $urandom_range(0, 3);
    end
    if (cyc == exp_launch_tick) begin
      check("launch_if_base",   if_base,   (cur_layer % 2) ? PONG : PING);
      check("launch_of_base",   of_base,   (cur_layer % 2) ? PING : PONG);
      check("launch_layer_idx", layer_idx, cur_layer);
      struct_ready = 1'b0;
      eng_fc   = types[cur_layer];
      eng_wait = $urandom_range(3, 12);
      // Early done in the launch cycle must be ignored
      if ($urandom_range(0, 1) == 0) begin
        if (eng_fc) fc_done = 1'b1; else conv_done = 1'b1;
      end
    end
    if (cyc == exp_done_tick && !hold_rdy) begin
      check("final_layer_idx", layer_idx, n_layers);
      check("final_if_base",   if_base,   (n_layers % 2) ? PONG : PING);
      check("final_of_base",   of_base,   (n_layers % 2) ? PING : PONG);
    end
    // Structure block: raise the descriptor after a random wait
    if (rdy_wait == 0 && !hold_rdy) begin
      struct_ready    = 1'b1;
      layer_is_fc     = types[cur_layer];
      exp_launch_tick = cyc + 1;
      rdy_wait        = -1;
    end else if (rdy_wait > 0) begin
      rdy_wait--;
      layer_is_fc = 1'($urandom);
    end
    // Engines: real done of the launched engine, stray done of the other one
    if (eng_wait > 0) begin
      eng_wait--;
      if (eng_wait == 0) begin
        if (eng_fc) fc_done = 1'b1; else conv_done = 1'b1;
        cur_layer++;
        if (cur_layer < n_layers) exp_nl_tick = cyc + 2;
        else                      exp_done_tick = cyc + 3;
        eng_wait = -1;
      end else if (cyc == exp_launch_tick + 1 || $urandom_range(0, 2) == 0) begin
        if (eng_fc) conv_done = 1'b1; else fc_done = 1'b1;
      end
    end
  endtask

  task automatic clear_model();
    exp_nl_tick = -1; exp_launch_tick = -1; exp_done_tick = -1; busy_on_tick = -1;
    busy_exp = 1'b0; rdy_wait = -1; eng_wait = -1; n_layers = 0; cur_layer = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; struct_ready = 1'b0; conv_done = 1'b0; fc_done = 1'b0;
    clear_model();
    tick();
    tick();
    rst = 1'b0;
    check("rst_if_base",   if_base,   PING);
    check("rst_of_base",   of_base,   PONG);
    check("rst_layer_idx", layer_idx, 0);
  endtask

  // Issue a start (DUT idle) and seed the model with the run's expectations
  task automatic start_run(input int n, input bit rand_types, input logic [15:0] tv);
    n_layers  = n;
    cur_layer = 0;
    for (int i = 0; i < 16; i++) types[i] = rand_types ? 1'($urandom) : tv[i];
    cant_layers   = LB'(n);
    start         = 1'b1;
    busy_on_tick  = cyc + 1;
    exp_done_tick = -1;
    if (n == 0) exp_done_tick = cyc + 2;
    else        exp_nl_tick   = cyc + 1;
  endtask

  task automatic run_to_done(input string tag);
    int guard = 0;
    while (!(exp_done_tick >= 0 && cyc >= exp_done_tick) && guard < 3000) begin
      tick();
      guard++;
    end
    check({tag, "_bounded"}, guard < 3000, 1'b1);
  endtask

  initial begin
    cant_layers = '0;
    layer_is_fc = 1'b0;
    do_reset();

    // Idle: nothing moves without start
    for (int i = 0; i < 20; i++) tick();
    check("idle_if_base", if_base, PING);
    check("idle_of_base", of_base, PONG);

    // Three layers: conv, conv, fc
    start_run(3, 1'b0, 16'b0000_0000_0000_0100);
    run_to_done("three_layer");
    tick();

    // Zero layers: done only
    start_run(0, 1'b0, 16'h0000);
    run_to_done("zero_layer");

    // Random networks, including the largest layer count
    for (int r = 0; r < 6; r++) begin
      start_run($urandom_range(1, 6), 1'b1, 16'h0000);
      run_to_done("random_run");
      if ($urandom_range(0, 1) == 0) tick();
    end
    start_run(15, 1'b1, 16'h0000);
    run_to_done("max_layers");

    // Ignored start during RUN, then mid-run reset
    start_run(3, 1'b0, 16'b0000_0000_0000_0110);
    for (int g = 0; g < 500 && !(eng_wait > 0 && cur_layer == 1); g++) tick();
    check("reached_run", cur_layer, 1);
    start       = 1'b1;
    cant_layers = LB'(5);
    tick();
    tick();
    do_reset();
    start_run(2, 1'b1, 16'h0000);
    run_to_done("after_reset");

`ifdef SCHED_WATCHDOG_EN
    begin
      int s;
      tick();
      s = cyc;
      hold_rdy = 1'b1;
      start_run(2, 1'b0, 16'h0000);
      exp_done_tick = s + 52;
      while (cyc < s + 50) tick();
      check("wdog_err_before", wdog_err, 1'b0);
      tick();
      check("wdog_err_set", wdog_err, 1'b1);
      run_to_done("watchdog");
      tick();
      check("wdog_err_sticky", wdog_err, 1'b1);
      hold_rdy = 1'b0;
      rdy_wait = -1;
      start_run(1, 1'b1, 16'h0000);
      run_to_done("after_wdog");
      check("wdog_err_cleared", wdog_err, 1'b0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
